// File: rtl/axi_line_pkg.sv
// Shared types and AXI encodings for the cache-line AXI master.
// Holds the engine state enum and the fixed AXI attribute values driven on AW/AR.
package axi_line_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    WB_B,
    RD_A,
    RD_D,
    DONE
  } state_t;

  localparam logic [2:0] SIZE_16B   = 3'b100;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] CACHE_MOD  = 4'b0011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_line_engine_if.sv
// AXI4 bus between the line engine (master) and the DDR interconnect (slave).
// Carries the AW, W, B, AR and R channels with single-beat attributes.
// The master modport drives addresses, data, VALIDs and B/R READYs; the slave drives the rest.
interface axi_line_engine_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 128
);

  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic                arvalid;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_line_engine.sv
// Purpose: one 128-bit cache-line AXI4 transaction per request: optional dirty writeback, then refill.
// Latency: zero-wait slave, clean miss resp_valid 3 cycles after accept; dirty miss 5 cycles.
// Backpressure: req_ready only while idle; VALIDs hold until their handshake, READYs only in B/R wait states.
// Ports: clk/rst (sync, active-high); req_* line request from the miss logic; resp_* line return
//   (resp_valid is a one-cycle pulse, resp_data holds until the next refill); m_axi master bus.
module axi_line_engine
  import axi_line_pkg::*;
#(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wb,
  input  logic [ADDR_W-1:0] req_wb_addr,
  input  logic [DATA_W-1:0] req_wb_data,
  input  logic [ADDR_W-1:0] req_rd_addr,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  axi_line_engine_if.master m_axi
);

  // Clears the byte offset within a 16-byte line.
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-4){1'b1}}, 4'b0000};

  state_t            state;
  logic              aw_valid_q, w_valid_q, b_ready_q, ar_valid_q, r_ready_q;
  logic              aw_done, w_done, err;
  logic [ADDR_W-1:0] wb_addr_q, rd_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              aw_fin, w_fin, r_bad;

  // A channel counts as finished if it completed earlier or completes on this edge,
  // so AW and W may finish in either order or together.
  assign aw_fin = aw_done | (aw_valid_q & m_axi.awready);
  assign w_fin  = w_done  | (w_valid_q  & m_axi.wready);
  assign r_bad  = (m_axi.rresp != RESP_OKAY) | ~m_axi.rlast;

  assign req_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      err        <= 1'b0;
      wb_addr_q  <= '0;
      rd_addr_q  <= '0;
      wb_data_q  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wb_addr_q <= req_wb_addr & LINE_MASK;
            rd_addr_q <= req_rd_addr & LINE_MASK;
            wb_data_q <= req_wb_data;
            err       <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            if (req_wb) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              state      <= WB;
            end else begin
              ar_valid_q <= 1'b1;
              state      <= RD_A;
            end
          end
        end
        WB: begin
          if (aw_valid_q && m_axi.awready) begin
            aw_valid_q <= 1'b0;
            aw_done    <= 1'b1;
          end
          if (w_valid_q && m_axi.wready) begin
            w_valid_q <= 1'b0;
            w_done    <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            b_ready_q <= 1'b1;
            state     <= WB_B;
          end
        end
        WB_B: begin
          if (m_axi.bvalid) begin
            b_ready_q  <= 1'b0;
            err        <= err | (m_axi.bresp != RESP_OKAY);
            // A failed writeback still proceeds to the refill.
            ar_valid_q <= 1'b1;
            state      <= RD_A;
          end
        end
        RD_A: begin
          if (m_axi.arready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state      <= RD_D;
          end
        end
        RD_D: begin
          if (m_axi.rvalid) begin
            r_ready_q  <= 1'b0;
            resp_data  <= m_axi.rdata;
            err        <= err | r_bad;
            resp_err   <= err | r_bad;
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_axi.awaddr  = wb_addr_q;
  assign m_axi.awlen   = 8'd0;
  assign m_axi.awsize  = SIZE_16B;
  assign m_axi.awburst = BURST_INCR;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = CACHE_MOD;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awqos   = 4'd0;
  assign m_axi.awvalid = aw_valid_q;

  assign m_axi.wdata   = wb_data_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = 1'b1;
  assign m_axi.wvalid  = w_valid_q;

  assign m_axi.bready  = b_ready_q;

  assign m_axi.araddr  = rd_addr_q;
  assign m_axi.arlen   = 8'd0;
  assign m_axi.arsize  = SIZE_16B;
  assign m_axi.arburst = BURST_INCR;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = CACHE_MOD;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arqos   = 4'd0;
  assign m_axi.arvalid = ar_valid_q;

  assign m_axi.rready  = r_ready_q;

endmodule

// File: tb/tb_axi_line_engine.sv
// Directed bench for axi_line_engine: a configurable AXI slave plus handshake monitor,
// and a linear sequence of line requests with hand-computed expectations.
module tb_axi_line_engine;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_wb;
  logic [26:0]   req_wb_addr, req_rd_addr;
  logic [127:0]  req_wb_data;
  logic          resp_valid, resp_err;
  logic [127:0]  resp_data;

  axi_line_engine_if #(.ADDR_W(27), .DATA_W(128)) m_axi ();

  axi_line_engine #(.ADDR_W(27), .DATA_W(128)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wb      (req_wb),
    .req_wb_addr (req_wb_addr),
    .req_wb_data (req_wb_data),
    .req_rd_addr (req_rd_addr),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .m_axi       (m_axi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Slave response settings, written only by the stimulus block.
  int           aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]   bresp_k = 2'b00, rresp_k = 2'b00;
  logic         rlast_k = 1'b1;
  logic [127:0] rdata_k = '0;

  // Slave state and monitor records, written only by the slave process.
  int           aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic         aw_ok, w_ok, b_pend, r_pend;
  int           aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0, resp_n = 0;
  int           aw_hs_cyc, w_hs_cyc, b_hs_cyc, ar_hs_cyc, resp_cyc;
  int           awv_n = 0, wv_n = 0, rstall_n = 0, proto_bad = 0;
  int           resp_cyc_a [32];
  logic [26:0]  cap_awaddr, cap_araddr;
  logic [127:0] cap_wdata, cap_rdata;
  logic [15:0]  cap_wstrb;
  logic         cap_wlast, cap_rerr;
  logic [26:0]  cap_awconst, cap_arconst;
  logic         prev_rst = 1'b1;
  logic         prev_awv, prev_awr, prev_wv, prev_wr, prev_arv, prev_arr;
  logic [26:0]  prev_awaddr, prev_araddr;
  logic [127:0] prev_wdata;

  localparam logic [26:0] AXCONST = {8'h00, 3'b100, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0};

  // Slave inputs change on the falling edge, so each decision made here is the
  // handshake outcome for the rising edge that follows.
  always @(negedge clk) begin
    if (rst) begin
      m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.bvalid = 1'b0; m_axi.bresp = 2'b00;
      m_axi.arready = 1'b0; m_axi.rvalid = 1'b0; m_axi.rdata = '0; m_axi.rresp = 2'b00;
      m_axi.rlast = 1'b0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_ok = 1'b0; w_ok = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
      prev_rst = 1'b1;
    end else begin
      if (!prev_rst && prev_awv && !prev_awr)
        assert (m_axi.awvalid === 1'b1 && m_axi.awaddr === prev_awaddr) else begin
          proto_bad++;
          $error("FAIL aw_stable: awvalid=%b awaddr=%h, required 1/%h", m_axi.awvalid, m_axi.awaddr, prev_awaddr);
        end
      if (!prev_rst && prev_wv && !prev_wr)
        assert (m_axi.wvalid === 1'b1 && m_axi.wdata === prev_wdata) else begin
          proto_bad++;
          $error("FAIL w_stable: wvalid=%b wdata=%h, required 1/%h", m_axi.wvalid, m_axi.wdata, prev_wdata);
        end
      if (!prev_rst && prev_arv && !prev_arr)
        assert (m_axi.arvalid === 1'b1 && m_axi.araddr === prev_araddr) else begin
          proto_bad++;
          $error("FAIL ar_stable: arvalid=%b araddr=%h, required 1/%h", m_axi.arvalid, m_axi.araddr, prev_araddr);
        end

      // B and R go first so a response never appears in the same cycle as its request.
      if (b_pend) begin
        m_axi.bvalid = (b_cnt >= b_delay);
        if (!m_axi.bvalid) b_cnt++;
      end else m_axi.bvalid = 1'b0;
      m_axi.bresp = bresp_k;
      if (m_axi.bvalid && m_axi.bready) begin
        b_hs_n++; b_hs_cyc = cyc; b_pend = 1'b0; b_cnt = 0;
      end

      if (r_pend) begin
        m_axi.rvalid = (r_cnt >= r_delay);
        if (!m_axi.rvalid) r_cnt++;
      end else m_axi.rvalid = 1'b0;
      m_axi.rdata = rdata_k; m_axi.rresp = rresp_k; m_axi.rlast = rlast_k;
      if (m_axi.rready && !m_axi.rvalid) rstall_n++;
      if (m_axi.rvalid && m_axi.rready) begin
        r_hs_n++; r_pend = 1'b0; r_cnt = 0;
      end

      if (m_axi.awvalid) begin
        awv_n++;
        m_axi.awready = (aw_cnt >= aw_delay);
        if (!m_axi.awready) aw_cnt++;
      end else m_axi.awready = 1'b0;
      if (m_axi.awvalid && m_axi.awready) begin
        aw_hs_n++; aw_hs_cyc = cyc; aw_cnt = 0; aw_ok = 1'b1;
        cap_awaddr  = m_axi.awaddr;
        cap_awconst = {m_axi.awlen, m_axi.awsize, m_axi.awburst, m_axi.awlock,
                       m_axi.awcache, m_axi.awprot, m_axi.awqos};
      end

      if (m_axi.wvalid) begin
        wv_n++;
        m_axi.wready = (w_cnt >= w_delay);
        if (!m_axi.wready) w_cnt++;
      end else m_axi.wready = 1'b0;
      if (m_axi.wvalid && m_axi.wready) begin
        w_hs_n++; w_hs_cyc = cyc; w_cnt = 0; w_ok = 1'b1;
        cap_wdata = m_axi.wdata; cap_wstrb = m_axi.wstrb; cap_wlast = m_axi.wlast;
      end
      if (aw_ok && w_ok) begin
        b_pend = 1'b1; aw_ok = 1'b0; w_ok = 1'b0;
      end

      if (m_axi.arvalid) begin
        m_axi.arready = (ar_cnt >= ar_delay);
        if (!m_axi.arready) ar_cnt++;
      end else m_axi.arready = 1'b0;
      if (m_axi.arvalid && m_axi.arready) begin
        ar_hs_n++; ar_hs_cyc = cyc; ar_cnt = 0; r_pend = 1'b1;
        cap_araddr  = m_axi.araddr;
        cap_arconst = {m_axi.arlen, m_axi.arsize, m_axi.arburst, m_axi.arlock,
                       m_axi.arcache, m_axi.arprot, m_axi.arqos};
      end

      if (resp_valid) begin
        resp_cyc_a[resp_n % 32] = cyc;
        resp_n++;
        resp_cyc = cyc; cap_rdata = resp_data; cap_rerr = resp_err;
      end

      prev_awv = m_axi.awvalid; prev_awr = m_axi.awready; prev_awaddr = m_axi.awaddr;
      prev_wv  = m_axi.wvalid;  prev_wr  = m_axi.wready;  prev_wdata  = m_axi.wdata;
      prev_arv = m_axi.arvalid; prev_arr = m_axi.arready; prev_araddr = m_axi.araddr;
      prev_rst = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wb, input logic [26:0] wa, input logic [127:0] wd,
                       input logic [26:0] ra, output int c0);
    for (int i = 0; i < 50 && req_ready !== 1'b1; i++) tick();
    chk("issue_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_wb = wb; req_wb_addr = wa; req_wb_data = wd; req_rd_addr = ra;
    c0 = cyc;
    tick();
    // Scramble the request fields: the engine must have registered them.
    req_valid = 1'b0; req_wb = ~wb; req_wb_addr = ~wa; req_wb_data = ~wd; req_rd_addr = ~ra;
  endtask

  task automatic wait_resp(input string tag, input int n0);
    for (int i = 0; i < 100 && resp_n == n0; i++) tick();
    chk({tag, "_resp_count"}, resp_n, n0 + 1);
  endtask

  int c0, n0, aw0, wv0, awv0, ar0, b0, rs0;
  int acc;
  int acc_cyc [4];

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wb = 1'b0;
    req_wb_addr = '0; req_rd_addr = '0; req_wb_data = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_axi_ctl", {m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready}, 5'b0);
    chk("rst_resp", {resp_valid, resp_err}, 2'b00);
    chk("rst_resp_data", resp_data, 128'h0);
    rst = 1'b0;
    tick();
    chk("idle_req_ready", req_ready, 1'b1);

    // 1: clean miss, zero-wait slave
    rdata_k = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    n0 = resp_n; awv0 = awv_n; wv0 = wv_n; ar0 = ar_hs_n;
    issue(1'b0, 27'h5555555, 128'h0, 27'h0123457, c0);
    wait_resp("t1", n0);
    chk("t1_araddr", cap_araddr, 27'h0123450);
    chk("t1_ar_const", cap_arconst, AXCONST);
    chk("t1_ar_cycle", ar_hs_cyc, c0 + 1);
    chk("t1_resp_cycle", resp_cyc, c0 + 3);
    chk("t1_resp_data", cap_rdata, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("t1_resp_err", cap_rerr, 1'b0);
    chk("t1_no_aw_w", (awv_n - awv0) + (wv_n - wv0), 0);
    tick();
    chk("t1_pulse_width", resp_valid, 1'b0);
    chk("t1_data_held", resp_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("t1_back_idle", req_ready, 1'b1);

    // 2: dirty miss, AWREADY 3 cycles late, WREADY immediate
    aw_delay = 3;
    rdata_k = 128'hCAFEF00D_0000_1111_2222_3333_4444_5555;
    n0 = resp_n; awv0 = awv_n; wv0 = wv_n;
    issue(1'b1, 27'h3ABCDEF, 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE, 27'h0000F0F, c0);
    wait_resp("t2", n0);
    chk("t2_w_cycle", w_hs_cyc, c0 + 1);
    chk("t2_wvalid_cycles", wv_n - wv0, 1);
    chk("t2_aw_cycle", aw_hs_cyc, c0 + 4);
    chk("t2_awvalid_cycles", awv_n - awv0, 4);
    chk("t2_b_cycle", b_hs_cyc, c0 + 5);
    chk("t2_ar_cycle", ar_hs_cyc, c0 + 6);
    chk("t2_resp_cycle", resp_cyc, c0 + 8);
    chk("t2_awaddr", cap_awaddr, 27'h3ABCDE0);
    chk("t2_araddr", cap_araddr, 27'h0000F00);
    chk("t2_wdata", cap_wdata, 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE);
    chk("t2_wstrb_wlast", {cap_wstrb, cap_wlast}, {16'hFFFF, 1'b1});
    chk("t2_aw_const", cap_awconst, AXCONST);
    chk("t2_resp_data", cap_rdata, 128'hCAFEF00D_0000_1111_2222_3333_4444_5555);
    chk("t2_resp_err", cap_rerr, 1'b0);
    aw_delay = 0;

    // 3: dirty miss with SLVERR on B, then a clean miss clears the error
    bresp_k = 2'b10;
    rdata_k = 128'h1;
    n0 = resp_n; ar0 = ar_hs_n; b0 = b_hs_n;
    issue(1'b1, 27'h0000100, 128'h77, 27'h0000200, c0);
    wait_resp("t3", n0);
    chk("t3_b_done", b_hs_n - b0, 1);
    chk("t3_refill_issued", ar_hs_n - ar0, 1);
    chk("t3_resp_cycle", resp_cyc, c0 + 5);
    chk("t3_resp_err", cap_rerr, 1'b1);
    bresp_k = 2'b00;
    rdata_k = 128'h2;
    n0 = resp_n;
    issue(1'b0, 27'h0, 128'h0, 27'h0000300, c0);
    wait_resp("t3b", n0);
    chk("t3b_resp_err", cap_rerr, 1'b0);
    chk("t3b_resp_data", cap_rdata, 128'h2);

    // 4: R stalled 10 cycles, RLAST low
    r_delay = 10; rlast_k = 1'b0;
    rdata_k = 128'hABCD;
    n0 = resp_n; rs0 = rstall_n;
    issue(1'b0, 27'h0, 128'h0, 27'h0400000, c0);
    wait_resp("t4", n0);
    chk("t4_rready_held", rstall_n - rs0, 10);
    chk("t4_resp_cycle", resp_cyc, c0 + 13);
    chk("t4_resp_err", cap_rerr, 1'b1);
    chk("t4_resp_data", cap_rdata, 128'hABCD);
    r_delay = 0; rlast_k = 1'b1;

    // 5: reset while waiting on B
    b_delay = 20;
    issue(1'b1, 27'h0000500, 128'h55, 27'h0000600, c0);
    for (int i = 0; i < 20 && m_axi.bready !== 1'b1; i++) tick();
    chk("t5_in_wb_b", m_axi.bready, 1'b1);
    n0 = resp_n;
    rst = 1'b1;
    tick();
    chk("t5_rst_axi_ctl", {m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready}, 5'b0);
    chk("t5_rst_resp_ready", {resp_valid, req_ready}, 2'b00);
    rst = 1'b0;
    b_delay = 0;
    tick();
    chk("t5_ready_after_rst", req_ready, 1'b1);
    repeat (30) tick();
    chk("t5_no_resp", resp_n, n0);
    rdata_k = 128'h5A5A;
    issue(1'b0, 27'h0, 128'h0, 27'h0000700, c0);
    wait_resp("t5b", n0);
    chk("t5b_resp_cycle", resp_cyc, c0 + 3);
    chk("t5b_resp", {cap_rdata, cap_rerr}, {128'h5A5A, 1'b0});

    // 6: four back-to-back requests with req_valid held high
    rdata_k = 128'h600D;
    n0 = resp_n; acc = 0;
    req_valid = 1'b1; req_wb = 1'b0; req_rd_addr = 27'h0000810;
    for (int i = 0; i < 300 && acc < 4; i++) begin
      if (req_ready === 1'b1) begin
        acc_cyc[acc] = cyc;
        acc++;
      end
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 100 && resp_n < n0 + 4; i++) tick();
    chk("t6_accepts", acc, 4);
    chk("t6_resps", resp_n - n0, 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t6_resp_cycle_%0d", k), resp_cyc_a[(n0 + k) % 32], acc_cyc[k] + 3);
    for (int k = 1; k < 4; k++)
      chk($sformatf("t6_accept_gap_%0d", k), acc_cyc[k], resp_cyc_a[(n0 + k - 1) % 32] + 1);
    chk("t6_araddr", cap_araddr, 27'h0000810);

    chk("protocol_violations", proto_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
